// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine: clips a CPU-issued rectangle to the framebuffer and
// streams one pixel write per accepted cycle in row-major order.
module fb_fill_engine #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int ADDR_W    = 17
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [8:0]        CmdX0,
    input  logic [7:0]        CmdY0,
    input  logic [8:0]        CmdW,
    input  logic [7:0]        CmdH,
    input  logic [7:0]        CmdColor,
    output logic              FBWriteEnable,
    output logic [ADDR_W-1:0] FBWriteAddress,
    output logic [7:0]        FBWriteData,
    input  logic              FBWriteReady,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    localparam logic [9:0]        FB_W10 = 10'(FB_WIDTH);
    localparam logic [8:0]        FB_H9  = 9'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_WIDTH);

    state_t            state_q, state_d;
    logic [8:0]        x0_q, x0_d, w_q, w_d, x_q, x_d;
    logic [7:0]        y0_q, y0_d, h_q, h_d, y_q, y_d;
    logic [7:0]        color_q, color_d;
    logic [9:0]        xend_q, xend_d;
    logic [8:0]        yend_q, yend_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;

    logic [9:0]        x_sum, x_inc;
    logic [8:0]        y_sum, y_inc;
    logic [ADDR_W-1:0] row_first, row_next;
    logic              empty;

    assign x_sum     = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum     = {1'b0, y0_q} + {1'b0, h_q};
    assign x_inc     = {1'b0, x_q} + 10'd1;
    assign y_inc     = {1'b0, y_q} + 9'd1;
    assign row_first = ADDR_W'(y0_q) * FB_W_A;
    assign row_next  = row_base_q + FB_W_A;
    assign empty     = (w_q == 9'd0) || (h_q == 8'd0) ||
                       ({1'b0, x0_q} >= FB_W10) || ({1'b0, y0_q} >= FB_H9);

    // Outputs come only from registered state so Cmd* never reaches them combinationally.
    assign CmdReady       = (state_q == IDLE);
    assign FBWriteEnable  = (state_q == FILL);
    assign Busy           = (state_q != IDLE);
    assign Done           = (state_q == DONE);
    assign FBWriteAddress = addr_q;
    assign FBWriteData    = color_q;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_d        = x_q;
        y_d        = y_q;
        xend_d     = xend_q;
        yend_d     = yend_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    x0_d    = CmdX0;
                    y0_d    = CmdY0;
                    w_d     = CmdW;
                    h_d     = CmdH;
                    color_d = CmdColor;
                    state_d = CLIP;
                end
            end
            CLIP: begin
                xend_d     = (x_sum > FB_W10) ? FB_W10 : x_sum;
                yend_d     = (y_sum > FB_H9) ? FB_H9 : y_sum;
                x_d        = x0_q;
                y_d        = y0_q;
                row_base_d = row_first;
                addr_d     = row_first + ADDR_W'(x0_q);
                state_d    = empty ? DONE : FILL;
            end
            FILL: begin
                // Everything holds while the framebuffer stalls.
                if (FBWriteReady) begin
                    if (x_inc < xend_q) begin
                        x_d    = x_q + 9'd1;
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else if (y_inc < yend_q) begin
                        x_d        = x0_q;
                        y_d        = y_q + 8'd1;
                        row_base_d = row_next;
                        addr_d     = row_next + ADDR_W'(x0_q);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            xend_q     <= '0;
            yend_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xend_q     <= xend_d;
            yend_q     <= yend_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

endmodule
